// File: rtl/idp_pkg.sv
// Shared definitions for the idp lane sequencer: phase encodings seen by the
// idp lane, the phase type, and the default word widths.
package idp_pkg;

    // Phase encodings on the lane's state bus.
    localparam logic [1:0] STOP_ST = 2'b00;
    localparam logic [1:0] COST_ST = 2'b01;
    localparam logic [1:0] ROOT_ST = 2'b10;
    localparam logic [1:0] SAVE_ST = 2'b11;

    typedef enum logic [1:0] {
        PH_STOP = STOP_ST,
        PH_COST = COST_ST,
        PH_ROOT = ROOT_ST,
        PH_SAVE = SAVE_ST
    } phase_e;

    // Default widths: each also equals the number of cycles spent in its phase.
    localparam int COST_W = 8;
    localparam int ROOT_W = 16;
    localparam int RES_W  = 8;

    // Width of a phase down-counter able to count the longest phase.
    function automatic int phase_cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/idp_shreg.sv
// Parallel-load shift register. Shifts toward bit 0, so q[0] is the serial
// (LSB-first) output and serial_in enters at the MSB.
module idp_shreg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    input  logic         serial_in,
    output logic [W-1:0] q
);

    // Load has priority over shift; otherwise the contents hold.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: these are a handful of flops, not a memory array, so they take the
        // async reset like any other state and never show stale data after reset.
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {serial_in, q[W-1:1]};
        end
    end

endmodule

// File: rtl/idp_sequencer.sv
// Word-parallel front end for one idp bit-serial lane. Accepts a request,
// walks STOP->COST->ROOT->SAVE, serializes the words LSB-first onto the lane and
// collects result_data/conquest back into a parallel response.
// Optional feature: define IDP_SEQ_CONQUEST_COUNT_EN to add a saturating
// conquest_count output counting delivered conquest responses.
module idp_sequencer #(
    parameter int COST_W = 8,
    parameter int ROOT_W = 16,
    parameter int RES_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_nbr_cost,
    input  logic [COST_W-1:0] in_own_cost,
    input  logic [ROOT_W-1:0] in_nbr_root,
    input  logic [ROOT_W-1:0] in_own_root,
    input  logic [ROOT_W-1:0] in_own_pred,
    input  logic [ROOT_W-1:0] in_cand_pred,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic              out_conquest,
    output logic [1:0]        state,
    output logic              extern_data,
    output logic              direction,
    output logic              root_carry_in,
    output logic [1:0]        intern_data,
    input  logic              result_data,
    input  logic              conquest
`ifdef IDP_SEQ_CONQUEST_COUNT_EN
    ,
    output logic [15:0]       conquest_count
`endif
);
    import idp_pkg::*;

    localparam int CNT_W = phase_cnt_w(COST_W, ROOT_W, RES_W);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alive_q;
    logic             set_valid;
    logic             accept, consume, last_save;

    logic [COST_W-1:0] nbr_cost_sr, own_cost_sr;
    logic [ROOT_W-1:0] nbr_root_sr, own_root_sr, own_pred_sr, cand_pred_sr;
    logic              unused_sr_bits;

    // alive_q keeps in_ready/intern_data at their reset values until the first edge.
    assign in_ready      = alive_q && (phase_q == PH_STOP) && !(out_valid && !out_ready);
    assign accept        = in_valid && in_ready;
    assign consume       = out_valid && out_ready;
    assign last_save     = (phase_q == PH_SAVE) && (cnt_q == '0);
    assign state         = phase_q;
    assign root_carry_in = 1'b0;

    // Only the serial bit of each field register is used by the lane.
    assign unused_sr_bits = ^{nbr_cost_sr[COST_W-1:1], own_cost_sr[COST_W-1:1],
                              nbr_root_sr[ROOT_W-1:1], own_root_sr[ROOT_W-1:1],
                              own_pred_sr[ROOT_W-1:1], cand_pred_sr[ROOT_W-1:1]};

    // Phase register, shared phase down-counter and the post-reset arm flag.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees
        // the pre-edge value of every other flop, independent of statement order.
        if (!reset_n) begin
            phase_q <= PH_STOP;
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            alive_q <= 1'b1;
        end
    end

    // Next phase/count plus the lane-side mux; every lane bit comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        set_valid   = 1'b0;
        extern_data = 1'b0;
        direction   = 1'b0;
        intern_data = 2'b00;
        case (phase_q)
            PH_STOP: begin
                // Preload the idp carries for the two's-complement compare.
                intern_data = alive_q ? 2'b11 : 2'b00;
                if (accept) begin
                    phase_d = PH_COST;
                    cnt_d   = CNT_W'(COST_W - 1);
                end
            end
            PH_COST: begin
                extern_data = nbr_cost_sr[0];
                intern_data = {2{own_cost_sr[0]}};
                if (cnt_q == '0) begin
                    phase_d = PH_ROOT;
                    cnt_d   = CNT_W'(ROOT_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PH_ROOT: begin
                extern_data = nbr_root_sr[0];
                intern_data = {own_pred_sr[0], own_root_sr[0]};
                direction   = cand_pred_sr[0];
                if (cnt_q == '0) begin
                    phase_d = PH_SAVE;
                    cnt_d   = CNT_W'(RES_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PH_SAVE: begin
                if (cnt_q == '0) begin
                    phase_d   = PH_STOP;
                    set_valid = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: phase_d = PH_STOP;
        endcase
    end

    // Response handshake flag and the conquest bit captured in the last SAVE cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_conquest <= 1'b0;
        end else begin
            if (set_valid) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (last_save) begin
                out_conquest <= conquest;
            end
        end
    end

`ifdef IDP_SEQ_CONQUEST_COUNT_EN
    // Saturating count of delivered responses that carried a conquest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conquest_count <= '0;
        end else if (consume && out_conquest && (conquest_count != 16'hFFFF)) begin
            conquest_count <= conquest_count + 16'd1;
        end
    end
`endif

    // Field serializers: load on accept, shift during their own phase.
    idp_shreg #(.W(COST_W)) u_nbr_cost (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_COST),
        .load_data(in_nbr_cost), .serial_in(1'b0), .q(nbr_cost_sr)
    );
    idp_shreg #(.W(COST_W)) u_own_cost (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_COST),
        .load_data(in_own_cost), .serial_in(1'b0), .q(own_cost_sr)
    );
    idp_shreg #(.W(ROOT_W)) u_nbr_root (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_ROOT),
        .load_data(in_nbr_root), .serial_in(1'b0), .q(nbr_root_sr)
    );
    idp_shreg #(.W(ROOT_W)) u_own_root (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_ROOT),
        .load_data(in_own_root), .serial_in(1'b0), .q(own_root_sr)
    );
    idp_shreg #(.W(ROOT_W)) u_own_pred (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_ROOT),
        .load_data(in_own_pred), .serial_in(1'b0), .q(own_pred_sr)
    );
    idp_shreg #(.W(ROOT_W)) u_cand_pred (
        .clock(clock), .reset_n(reset_n), .load(accept), .shift(phase_q == PH_ROOT),
        .load_data(in_cand_pred), .serial_in(1'b0), .q(cand_pred_sr)
    );

    // Result collector: result_data enters at the MSB, so the first sample ends in bit 0.
    idp_shreg #(.W(RES_W)) u_result (
        .clock(clock), .reset_n(reset_n), .load(1'b0), .shift(phase_q == PH_SAVE),
        .load_data('0), .serial_in(result_data), .q(out_result)
    );

endmodule

// File: tb/tb_idp_sequencer.sv
// Directed bench for idp_sequencer: reset values, serialized lane streams,
// response capture, back-pressure, mid-transaction reset and (when
// IDP_SEQ_CONQUEST_COUNT_EN is defined) the conquest counter.
module tb_idp_sequencer;

    localparam int CW = 8;
    localparam int RW = 16;
    localparam int SW = 8;
    localparam int TXN_CYC = CW + RW + SW;

    typedef struct {
        logic [CW-1:0] nbr_cost;
        logic [CW-1:0] own_cost;
        logic [RW-1:0] nbr_root;
        logic [RW-1:0] own_root;
        logic [RW-1:0] own_pred;
        logic [RW-1:0] cand_pred;
        logic [SW-1:0] res;      // result_data bits driven LSB first
        logic          conq;     // conquest driven in the last SAVE cycle
    } req_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready;
    logic [CW-1:0] in_nbr_cost, in_own_cost;
    logic [RW-1:0] in_nbr_root, in_own_root, in_own_pred, in_cand_pred;
    logic          out_valid, out_ready;
    logic [SW-1:0] out_result;
    logic          out_conquest;
    logic [1:0]    state;
    logic          extern_data, direction, root_carry_in;
    logic [1:0]    intern_data;
    logic          result_data, conquest;
`ifdef IDP_SEQ_CONQUEST_COUNT_EN
    logic [15:0]   conquest_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    idp_sequencer #(.COST_W(CW), .ROOT_W(RW), .RES_W(SW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_nbr_cost(in_nbr_cost), .in_own_cost(in_own_cost),
        .in_nbr_root(in_nbr_root), .in_own_root(in_own_root),
        .in_own_pred(in_own_pred), .in_cand_pred(in_cand_pred),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_conquest(out_conquest),
        .state(state), .extern_data(extern_data), .direction(direction),
        .root_carry_in(root_carry_in), .intern_data(intern_data),
        .result_data(result_data), .conquest(conquest)
`ifdef IDP_SEQ_CONQUEST_COUNT_EN
        , .conquest_count(conquest_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input req_t r);
        in_nbr_cost  = r.nbr_cost;
        in_own_cost  = r.own_cost;
        in_nbr_root  = r.nbr_root;
        in_own_root  = r.own_root;
        in_own_pred  = r.own_pred;
        in_cand_pred = r.cand_pred;
        in_valid     = 1'b1;
    endtask

    // Present a request and wait (bounded) for the edge that accepts it.
    task automatic request(input req_t r);
        logic ok;
        ok = 1'b0;
        set_req(r);
        for (int k = 0; k < 60; k++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    // Starting just after the accept edge, check every lane cycle and act as the
    // idp lane in SAVE. abort_j >= 0 pulses reset in that cycle instead.
    task automatic walk(input req_t r, input int abort_j);
        logic [1:0] e_st, e_int;
        logic       e_ext, e_dir;
        for (int j = 0; j < TXN_CYC; j++) begin
            if (j < CW) begin
                e_st = 2'b01; e_ext = r.nbr_cost[j];
                e_int = {r.own_cost[j], r.own_cost[j]}; e_dir = 1'b0;
            end else if (j < CW + RW) begin
                e_st = 2'b10; e_ext = r.nbr_root[j-CW];
                e_int = {r.own_pred[j-CW], r.own_root[j-CW]}; e_dir = r.cand_pred[j-CW];
            end else begin
                e_st = 2'b11; e_ext = 1'b0; e_int = 2'b00; e_dir = 1'b0;
            end
            check($sformatf("state j=%0d", j), state, e_st);
            check($sformatf("extern_data j=%0d", j), extern_data, e_ext);
            check($sformatf("intern_data j=%0d", j), intern_data, e_int);
            check($sformatf("direction j=%0d", j), direction, e_dir);
            check($sformatf("root_carry_in j=%0d", j), root_carry_in, 0);
            check($sformatf("out_valid busy j=%0d", j), out_valid, 0);
            if (j == abort_j) begin
                reset_n = 1'b0;
                #1;
                check("abort state", state, 2'b00);
                check("abort out_valid", out_valid, 0);
                check("abort intern_data", intern_data, 2'b00);
                check("abort extern_data", extern_data, 0);
                #1;
                reset_n = 1'b1;
                return;
            end
            if (j >= CW + RW) begin
                result_data = r.res[j-CW-RW];
                // Opposite value outside the last cycle: only the last sample may count.
                conquest = (j == TXN_CYC - 1) ? r.conq : ~r.conq;
            end else begin
                result_data = 1'b0;
                conquest    = 1'b0;
            end
            tick();
        end
        result_data = 1'b0;
        conquest    = 1'b0;
        check("resp out_valid", out_valid, 1);
        check("resp out_result", out_result, r.res);
        check("resp out_conquest", out_conquest, r.conq);
        check("resp state", state, 2'b00);
        check("resp intern_data", intern_data, 2'b11);
    endtask

    initial begin
        req_t ra, rb, rc, rd, rq;

        // Result pattern 1,1,0,0,0,0,0,1 LSB-first is 8'h83.
        ra = '{8'hA5, 8'h3C, 16'h1234, 16'hBEEF, 16'h0F0F, 16'h00FF, 8'h83, 1'b1};
        rb = '{8'h5A, 8'hC3, 16'hABCD, 16'h0001, 16'h8000, 16'hF00F, 8'h4E, 1'b0};
        rc = '{8'hFF, 8'h00, 16'hFFFF, 16'h5555, 16'hAAAA, 16'hFFFF, 8'hFF, 1'b1};
        rd = '{8'h01, 8'h80, 16'h8001, 16'h7FFE, 16'h0000, 16'h1111, 8'h5A, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        result_data = 1'b0; conquest = 1'b0;
        in_nbr_cost = '0; in_own_cost = '0; in_nbr_root = '0;
        in_own_root = '0; in_own_pred = '0; in_cand_pred = '0;

        // Reset values, then the first edge after release arms the sequencer.
        tick(); tick();
        check("rst state", state, 2'b00);
        check("rst intern_data", intern_data, 2'b00);
        check("rst extern_data", extern_data, 0);
        check("rst direction", direction, 0);
        check("rst root_carry_in", root_carry_in, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_result", out_result, 8'h00);
        check("rst out_conquest", out_conquest, 0);
        reset_n = 1'b1;
        #1;
        check("released in_ready", in_ready, 0);
        check("released intern_data", intern_data, 2'b00);
        tick();
        check("armed state", state, 2'b00);
        check("armed intern_data", intern_data, 2'b11);
        check("armed in_ready", in_ready, 1);

        // Single request; response lands 32 edges after the accept edge (T+33).
        request(ra);
        walk(ra, -1);

        // Back-pressure: response held, FSM parked in STOP, next request waits.
        set_req(rb);
        for (int k = 0; k < 10; k++) begin
            check("bp state", state, 2'b00);
            check("bp in_ready", in_ready, 0);
            check("bp out_valid", out_valid, 1);
            check("bp out_result", out_result, 8'h83);
            check("bp out_conquest", out_conquest, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        walk(rb, -1);
        out_ready = 1'b1;
        tick();
        check("consume out_valid", out_valid, 0);

        // Reset in ROOT cycle 5 aborts; no response may appear afterwards.
        request(rc);
        walk(rc, CW + 4);
        for (int k = 0; k < 40; k++) begin
            tick();
            check("post-abort out_valid", out_valid, 0);
        end
        check("post-abort state", state, 2'b00);
        check("post-abort in_ready", in_ready, 1);
        request(rd);
        walk(rd, -1);
        tick();
        check("rd consumed out_valid", out_valid, 0);

`ifdef IDP_SEQ_CONQUEST_COUNT_EN
        // Counter: 3 conquest + 2 non-conquest responses from a fresh reset.
        reset_n = 1'b0;
        #2;
        check("cnt rst", conquest_count, 16'h0000);
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            rq = rd;
            rq.conq = (t % 2 == 0);
            request(rq);
            walk(rq, -1);
        end
        tick();
        check("cnt 3 of 5", conquest_count, 16'd3);
        // Saturation: preload just below the limit, then deliver two conquests.
        force dut.conquest_count = 16'hFFFE;
        tick();
        release dut.conquest_count;
        rq = rd;
        rq.conq = 1'b1;
        for (int t = 0; t < 2; t++) begin
            request(rq);
            walk(rq, -1);
        end
        tick();
        check("cnt saturate", conquest_count, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
